// File: rtl/alu_pkg.sv
// Opcode set and FSM state encoding shared by the ALU and its UART command sequencer.
package alu_pkg;

    localparam int NB_OP_DEFAULT = 6;

    localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    function automatic logic is_valid_op(input logic [NB_OP_DEFAULT-1:0] op);
        logic v;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: v = 1'b1;
            default:                        v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags when
// TIMEOUT-1 is reached. The count holds at that value until cleared.
module frame_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_count;
    logic         w_expired;

    assign w_expired = (r_count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = w_expired;

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, drives the ALU operands,
// captures the result and hands it to the transmitter with a one-cycle start pulse.
module uart_alu_interface
    import alu_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int NB_OP   = NB_OP_DEFAULT,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_rx_done_tick,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done_tick,
    output logic [DBIT-1:0]  o_alu_a,
    output logic [DBIT-1:0]  o_alu_b,
    output logic [NB_OP-1:0] o_alu_op,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_op_err,
    output logic             o_overrun,
    output state_t           o_state
);

    // All handshakes are single-cycle pulses with no back-pressure: i_rx_done_tick
    // qualifies i_rx_data in its own cycle, o_tx_start qualifies o_tx_data, and the
    // transmitter answers with i_tx_done_tick; o_op_err/o_overrun fire in the
    // cycle of the offending byte.

    state_t            r_state;
    state_t            w_state_next;
    logic [DBIT-1:0]   r_alu_a;
    logic [DBIT-1:0]   r_alu_b;
    logic [NB_OP-1:0]  r_alu_op;
    logic [DBIT-1:0]   r_tx_data;
    logic [NB_OP-1:0]  w_op;
    logic              w_op_valid;
    logic              w_op_err;
    logic              w_overrun;
    logic              w_timer_en;
    logic              w_timer_clear;
    logic              w_expired;

    assign w_op       = i_rx_data[NB_OP-1:0];
    assign w_op_valid = is_valid_op(w_op);

    // Timer only runs mid-frame; any received byte or leaving the frame restarts it.
    assign w_timer_en    = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
    assign w_timer_clear = i_rx_done_tick || !w_timer_en;

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_err     = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            ST_WAIT_A: begin
                if (i_rx_done_tick) w_state_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_done_tick)  w_state_next = ST_WAIT_OP;
                else if (w_expired)  w_state_next = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (i_rx_done_tick) begin
                    if (w_op_valid) begin
                        w_state_next = ST_EXEC;
                    end else begin
                        w_op_err     = 1'b1;
                        w_state_next = ST_WAIT_A;
                    end
                end else if (w_expired) begin
                    w_state_next = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                w_overrun    = i_rx_done_tick;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                w_overrun    = i_rx_done_tick;
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                w_overrun = i_rx_done_tick;
                if (i_tx_done_tick) w_state_next = ST_WAIT_A;
            end
            default: begin
                w_state_next = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
        end else begin
            if (r_state == ST_WAIT_A && i_rx_done_tick) r_alu_a <= i_rx_data;
            if (r_state == ST_WAIT_B && i_rx_done_tick) r_alu_b <= i_rx_data;
            if (r_state == ST_WAIT_OP && i_rx_done_tick && w_op_valid) r_alu_op <= w_op;
            // Operands have been stable for a full cycle by EXEC, so the ALU has settled.
            if (r_state == ST_EXEC) r_tx_data <= i_alu_result;
        end
    end

    assign o_alu_a    = r_alu_a;
    assign o_alu_b    = r_alu_b;
    assign o_alu_op   = r_alu_op;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = (r_state == ST_SEND);
    assign o_busy     = (r_state == ST_EXEC) || (r_state == ST_SEND) || (r_state == ST_WAIT_TX);
    assign o_op_err   = w_op_err;
    assign o_overrun  = w_overrun;
    assign o_state    = r_state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: frames driven byte by byte, expected ALU results
// queued at stimulus time and popped when the transmitter start pulse appears.
module tb_uart_alu_interface;
    import alu_pkg::*;

    localparam int DBIT    = 8;
    localparam int NB_OP   = 6;
    localparam int TIMEOUT = 20;

    logic             clk;
    logic             reset;
    logic             rx_done_tick;
    logic [DBIT-1:0]  rx_data;
    logic [DBIT-1:0]  alu_result;
    logic             tx_done_tick;
    logic [DBIT-1:0]  alu_a;
    logic [DBIT-1:0]  alu_b;
    logic [NB_OP-1:0] alu_op;
    logic             tx_start;
    logic [DBIT-1:0]  tx_data;
    logic             busy;
    logic             op_err;
    logic             overrun;
    state_t           state;

    int total;
    int bad;
    logic [DBIT-1:0] exp_q[$];

    uart_alu_interface #(
        .DBIT    (DBIT),
        .NB_OP   (NB_OP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_rx_done_tick (rx_done_tick),
        .i_rx_data      (rx_data),
        .i_alu_result   (alu_result),
        .i_tx_done_tick (tx_done_tick),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_op_err       (op_err),
        .o_overrun      (overrun),
        .o_state        (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU, also used as the environment ALU feeding the DUT.
    function automatic logic [DBIT-1:0] alu_ref(input logic [DBIT-1:0] a,
                                                input logic [DBIT-1:0] b,
                                                input logic [NB_OP-1:0] op);
        logic [DBIT-1:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            6'h03:   r = DBIT'($signed(a) >>> b);
            6'h02:   r = a >> b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    // ---------------- driver tasks ----------------
    // Drives one byte in the cycle after the next posedge; returns just after the
    // accepting edge with the Mealy flags seen during the tick cycle.
    task automatic drive_byte(input logic [DBIT-1:0] b, output logic err, output logic ovr);
        @(posedge clk);
        #1;
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        err = op_err;
        ovr = overrun;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                              input logic [DBIT-1:0] op);
        logic err, ovr;
        drive_byte(a, err, ovr);
        drive_byte(b, err, ovr);
        exp_q.push_back(alu_ref(a, b, op[NB_OP-1:0]));
        drive_byte(op, err, ovr);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL frame_op_err: got %b want 0", err);
        end
    endtask

    // Called right after the opcode edge: tx_start must appear on the second negedge.
    task automatic wait_result(input string name);
        int   lat;
        logic seen;
        logic [DBIT-1:0] exp;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_busy_exec: got %b want 1", name, busy);
            end
        end
        total++;
        if (!seen || lat != 1) begin
            bad++;
            $display("FAIL %s_tx_start_latency: got seen=%b lat=%0d want lat=1", name, seen, lat);
        end
        if (seen) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (tx_data !== exp) begin
                bad++;
                $display("FAIL %s_tx_data: got %h want %h", name, tx_data, exp);
            end
        end
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_wait_tx: got tx_start=%b busy=%b want 0/1", name, tx_start, busy);
        end
    endtask

    task automatic finish_tx(input string name);
        @(posedge clk);
        #1;
        tx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_done_tick = 1'b0;
        total++;
        if (busy !== 1'b0 || state !== ST_WAIT_A) begin
            bad++;
            $display("FAIL %s_tx_done: got busy=%b state=%0d want 0/%0d", name, busy, state, ST_WAIT_A);
        end
    endtask

    task automatic expect_no_start(input string name, input int cycles);
        int starts;
        starts = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) starts++;
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("FAIL %s_no_tx_start: got %0d pulses want 0", name, starts);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        tx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({alu_a, alu_b, alu_op, tx_data} !== '0 ||
            {tx_start, busy, op_err, overrun} !== 4'b0 || state !== ST_WAIT_A) begin
            bad++;
            $display("FAIL reset_values: got a=%h b=%h op=%h tx=%h flags=%b state=%0d want all 0",
                     alu_a, alu_b, alu_op, tx_data, {tx_start, busy, op_err, overrun}, state);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic err, ovr;
        send_frame(8'h05, 8'h03, 8'h20);
        total++;
        if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20) begin
            bad++;
            $display("FAIL add_regs: got a=%h b=%h op=%h want 05/03/20", alu_a, alu_b, alu_op);
        end
        wait_result("add");
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL add_busy_hold: got %b want 1", busy);
        end
        finish_tx("add");
        // tx_done_tick in WAIT_A must not disturb anything
        @(posedge clk); #1 tx_done_tick = 1'b1;
        @(posedge clk); #1 tx_done_tick = 1'b0;
        total++;
        if (state !== ST_WAIT_A || busy !== 1'b0) begin
            bad++;
            $display("FAIL stray_tx_done: got state=%0d busy=%b want %0d/0", state, busy, ST_WAIT_A);
        end
        // Opcode upper bits are ignored: 0xA0 decodes as ADD
        send_frame(8'h10, 8'h22, 8'hA0);
        total++;
        if (alu_op !== 6'h20) begin
            bad++;
            $display("FAIL add_upper_bits: got op=%h want 20", alu_op);
        end
        wait_result("add_hi");
        finish_tx("add_hi");
        drive_byte(8'h00, err, ovr);
    endtask

    task automatic test_invalid_op();
        logic err, ovr;
        // Leftover A from the previous task: finish that frame with B, then a bad opcode.
        drive_byte(8'h0F, err, ovr);
        drive_byte(8'h3F, err, ovr);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL invalid_op_err: got %b want 1", err);
        end
        @(negedge clk);
        total++;
        if (op_err !== 1'b0 || state !== ST_WAIT_A || alu_op !== 6'h20) begin
            bad++;
            $display("FAIL invalid_after: got err=%b state=%0d op=%h want 0/%0d/20",
                     op_err, state, alu_op, ST_WAIT_A);
        end
        expect_no_start("invalid", 6);
        send_frame(8'h0C, 8'h0A, 8'h26);
        wait_result("xor_after_invalid");
        finish_tx("xor_after_invalid");
    endtask

    task automatic test_timeout();
        logic err, ovr;
        drive_byte(8'h11, err, ovr);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        total++;
        if (state !== ST_WAIT_B) begin
            bad++;
            $display("FAIL timeout_early: got state=%0d want %0d", state, ST_WAIT_B);
        end
        @(negedge clk);
        total++;
        if (state !== ST_WAIT_A || alu_a !== 8'h11) begin
            bad++;
            $display("FAIL timeout_expire: got state=%0d a=%h want %0d/11", state, alu_a, ST_WAIT_A);
        end
        send_frame(8'h01, 8'h02, 8'h24);
        total++;
        if (alu_a !== 8'h01 || alu_b !== 8'h02) begin
            bad++;
            $display("FAIL timeout_resync: got a=%h b=%h want 01/02", alu_a, alu_b);
        end
        wait_result("and_after_timeout");
        finish_tx("and_after_timeout");
    endtask

    task automatic test_overrun();
        logic err, ovr;
        send_frame(8'h40, 8'h02, 8'h02);
        wait_result("srl");
        drive_byte(8'h77, err, ovr);
        total++;
        if (ovr !== 1'b1 || alu_a !== 8'h40 || state !== ST_WAIT_TX) begin
            bad++;
            $display("FAIL overrun: got ovr=%b a=%h state=%0d want 1/40/%0d", ovr, alu_a, state, ST_WAIT_TX);
        end
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_stretch: got %b want 0", overrun);
        end
        finish_tx("srl");
        send_frame(8'h09, 8'h04, 8'h22);
        wait_result("sub_after_overrun");
        finish_tx("sub_after_overrun");
    endtask

    task automatic test_coincide();
        logic err, ovr;
        drive_byte(8'h81, err, ovr);
        drive_byte(8'h01, err, ovr);
        repeat (TIMEOUT - 2) @(posedge clk);
        exp_q.push_back(alu_ref(8'h81, 8'h01, 6'h03));
        drive_byte(8'h03, err, ovr);
        total++;
        if (state !== ST_EXEC) begin
            bad++;
            $display("FAIL coincide_exec: got state=%0d want %0d", state, ST_EXEC);
        end
        wait_result("coincide_sra");
        finish_tx("coincide_sra");
    endtask

    task automatic test_reset_mid();
        logic err, ovr;
        drive_byte(8'h33, err, ovr);
        drive_byte(8'h44, err, ovr);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({alu_a, alu_b, alu_op, tx_data} !== '0 || busy !== 1'b0 || state !== ST_WAIT_A) begin
            bad++;
            $display("FAIL reset_wait_op: got a=%h b=%h op=%h busy=%b state=%0d want 0",
                     alu_a, alu_b, alu_op, busy, state);
        end
        @(negedge clk) reset = 1'b0;
        expect_no_start("reset_wait_op", 8);
        send_frame(8'h55, 8'h0F, 8'h27);
        wait_result("nor");
        #1 reset = 1'b1;
        #1;
        total++;
        if (tx_data !== '0 || {tx_start, busy} !== 2'b00 || state !== ST_WAIT_A) begin
            bad++;
            $display("FAIL reset_wait_tx: got tx=%h start=%b busy=%b state=%0d want 0",
                     tx_data, tx_start, busy, state);
        end
        @(negedge clk) reset = 1'b0;
        expect_no_start("reset_wait_tx", 8);
    endtask

    task automatic test_back_to_back();
        logic [DBIT-1:0] ops [8];
        logic [DBIT-1:0] a, b, op;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
        for (int n = 0; n < 6; n++) begin
            a  = DBIT'($urandom_range(0, 255));
            b  = DBIT'($urandom_range(0, 7));
            op = ops[$urandom_range(0, 7)];
            send_frame(a, b, op);
            wait_result("random");
            finish_tx("random");
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_invalid_op();
        test_timeout();
        test_overrun();
        test_coincide();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Command-sequencing stage downstream of the UART receiver and upstream of the UART transmitter. Consumes received bytes (`rx_done_tick`/`rx_data`) as a three-byte frame: operand A, operand B, opcode. It latches the frame into registers driving the ALU, captures the ALU result, and hands it to the transmitter with a single-cycle start pulse. Includes an inter-byte timeout for resynchronisation and flags for invalid opcodes and dropped bytes.

## Interface
- `DBIT`, 8: data width of bytes, operands and result.
- `NB_OP`, 6: opcode width; taken from `rx_data[NB_OP-1:0]`, upper bits ignored.
- `TIMEOUT`, 1_000_000: clk cycles allowed between bytes of one frame.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_done_tick`  in  1  one-cycle pulse; `rx_data` valid in that cycle.
- `rx_data`  in  DBIT  received byte.
- `alu_result`  in  DBIT  combinational ALU output for current `alu_a`/`alu_b`/`alu_op`.
- `tx_done_tick`  in  1  one-cycle pulse from transmitter at end of stop bit.
- `alu_a`  out  DBIT  registered operand A.
- `alu_b`  out  DBIT  registered operand B.
- `alu_op`  out  NB_OP  registered opcode.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  DBIT  registered result; stable from `tx_start` until next capture.
- `busy`  out  1  high in EXEC, SEND, WAIT_TX.
- `op_err`  out  1  one-cycle pulse: invalid opcode received.
- `overrun`  out  1  one-cycle pulse: byte arrived while busy, dropped.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on `rx_done_tick`, `alu_a <= rx_data`, go to WAIT_B, clear timer.
- WAIT_B: on `rx_done_tick`, `alu_b <= rx_data`, go to WAIT_OP, clear timer.
- WAIT_OP: on `rx_done_tick` with valid opcode, `alu_op <= rx_data[NB_OP-1:0]`, go to EXEC. With an invalid opcode, pulse `op_err`, leave `alu_op` unchanged, go to WAIT_A.
- Valid opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
- EXEC: one cycle to let the ALU settle; `tx_data <= alu_result`; go to SEND.
- SEND: `tx_start = 1` for exactly this cycle; go to WAIT_TX.
- WAIT_TX: on `tx_done_tick`, go to WAIT_A. There is no timeout in this state.
- Timeout applies in WAIT_B and WAIT_OP only. The timer counts clk cycles since the last accepted byte. When it reaches `TIMEOUT-1` without `rx_done_tick`, return to WAIT_A and discard the partial frame. The registers keep their values.
- Simultaneous events: `rx_done_tick` in the same cycle the timeout expires means the byte is accepted and the timeout ignored.
- `rx_done_tick` in EXEC, SEND or WAIT_TX: byte dropped, `overrun` pulses in the same cycle.
- `tx_done_tick` outside WAIT_TX is ignored.

## Timing
- Reset values: state WAIT_A; `alu_a`, `alu_b`, `alu_op`, `tx_data` are 0; `tx_start`, `busy`, `op_err`, `overrun` are 0; timer 0.
- Register updates occur on the clk edge of the `rx_done_tick` cycle. New values are visible the next cycle.
- `tx_start` is asserted 2 cycles after the clk edge that accepts the opcode: EXEC, then SEND.
- `tx_start`, `op_err` and `overrun` are Moore/Mealy pulses of exactly one cycle and never stretch.
- Reset mid-frame or mid-transmission returns to WAIT_A immediately. `tx_start` is never re-issued for the aborted frame.

## Structure
- Shared package `alu_pkg`: opcode localparams (ADD…SRL) and the `NB_OP` default, shared with the ALU.
- Sub-module `frame_timer`: loadable counter with `clear`, `enable` and a `expired` output, parameterised by `TIMEOUT`. Width is `$clog2(TIMEOUT)`.
- The FSM and data registers live in `uart_alu_interface`.

## Test plan
- Bytes 0x05, 0x03, 0x20, with `alu_result` modelled as ADD → `alu_a`=0x05, `alu_b`=0x03, `alu_op`=0x20. `tx_start` pulses once 2 cycles after the third tick, with `tx_data`=0x08. `busy` stays high until `tx_done_tick`.
- Bytes 0xF0, 0x0F, 0x3F (invalid) → `op_err` pulses once, no `tx_start`, state is WAIT_A. The next valid frame is processed normally.
- Byte 0x11, then no byte for `TIMEOUT` cycles, then 0x01, 0x02, 0x24 → 0x01 is treated as A. Result is AND = 0x00, `tx_data`=0x00.
- `rx_done_tick` during WAIT_TX → `overrun` pulse, registers unchanged. A frame after `tx_done_tick` is accepted.
- `rx_done_tick` coinciding with timeout expiry in WAIT_OP → byte accepted as opcode, EXEC follows.
- `reset` asserted in WAIT_OP and in WAIT_TX → all outputs return to 0 immediately. No `tx_start` appears after release.
